round_robin_mux_arbiter: RTL and testbench

// Shares one W-bit mux datapath between N requesters through a round-robin

---
 rtl/round_robin_mux_arbiter.sv | 80 ++++++++
 tb/tb_round_robin_mux_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/round_robin_mux_arbiter.sv
// round_robin_mux_arbiter: N requesters share one W-bit mux path.
// A rotating-priority arbiter picks the winner, and its word is loaded into a
// one-entry output register that drives a single valid/ready channel.
module round_robin_mux_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_src,
  input  logic             out_ready
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] grant_idx;
  logic          grant_any;
  logic          load_ok;
  logic [SW:0]   cand;
  logic [SW:0]   ptr_inc;
  logic [SW-1:0] ptr_nxt;
  logic [W-1:0]  grant_data;

  // Rotating-priority scan starting at ptr; the register only loads when empty or draining
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_ready = '0;
    load_ok   = !out_valid || out_ready;
    for (int k = 0; k < int'(N); k++) begin
      cand = {1'b0, ptr} + (SW+1)'(k);
      if (cand >= (SW+1)'(N)) cand = cand - (SW+1)'(N);
      if (!grant_any && req_valid[cand[SW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[SW-1:0];
      end
    end
    if (rst || !load_ok) grant_any = 1'b0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  // Shared mux: steer the winner's word toward the output register
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (SW'(i) == grant_idx) grant_data = req_data[i*W +: W];
    end
  end

  // Pointer moves to the requester after the winner, wrapping modulo N
  always_comb begin
    ptr_inc = {1'b0, grant_idx} + (SW+1)'(1);
    ptr_nxt = ptr_inc[SW-1:0];
    if (ptr_inc >= (SW+1)'(N)) ptr_nxt = '0;
  end

  // Output register and priority pointer; a drain without a new grant empties the register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (grant_any) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_src   <= grant_idx;
      ptr       <= ptr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// Randomized bench for round_robin_mux_arbiter: an N=4 and an N=3 instance
// share stimulus and are each compared against a behavioural model.
module tb_round_robin_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid4 = '0;
  logic [31:0] req_data4 = '0;
  logic        out_ready = 1'b0;

  logic [2:0]  req_valid3;
  logic [23:0] req_data3;
  logic [3:0]  req_ready4;
  logic [2:0]  req_ready3;
  logic        out_valid4, out_valid3;
  logic [7:0]  out_data4, out_data3;
  logic [1:0]  out_src4, out_src3;

  int total = 0;
  int bad   = 0;

  // model state, index 0 = N=4 instance, index 1 = N=3 instance
  int m_valid [2];
  int m_data  [2];
  int m_src   [2];
  int m_ptr   [2];

  assign req_valid3 = req_valid4[2:0];
  assign req_data3  = req_data4[23:0];

  always #5 clk = ~clk;

  round_robin_mux_arbiter #(.N(4), .W(8)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_data(req_data4),
    .req_ready(req_ready4), .out_valid(out_valid4), .out_data(out_data4),
    .out_src(out_src4), .out_ready(out_ready)
  );

  round_robin_mux_arbiter #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_data(req_data3),
    .req_ready(req_ready3), .out_valid(out_valid3), .out_data(out_data3),
    .out_src(out_src3), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check grants, advance model, check outputs
  task automatic cycle(input logic r, input logic [3:0] v, input logic [31:0] d, input logic o);
    int n;
    int g;
    int idx;
    logic [3:0] exp_rdy;
    logic [3:0] got_rdy;
    @(negedge clk);
    rst = r; req_valid4 = v; req_data4 = d; out_ready = o;
    #1;
    for (int m = 0; m < 2; m++) begin
      n = (m == 0) ? 4 : 3;
      g = -1;
      exp_rdy = '0;
      if (!r && (m_valid[m] == 0 || o)) begin
        for (int k = 0; k < n; k++) begin
          idx = (m_ptr[m] + k) % n;
          if (g < 0 && v[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      got_rdy = (m == 0) ? req_ready4 : {1'b0, req_ready3};
      check((m == 0) ? "ready_n4" : "ready_n3", 32'(got_rdy), 32'(exp_rdy));
      check((m == 0) ? "onehot_n4" : "onehot_n3", 32'($onehot0(got_rdy)), 32'd1);
      if (r) begin
        m_valid[m] = 0; m_data[m] = 0; m_src[m] = 0; m_ptr[m] = 0;
      end else if (g >= 0) begin
        m_valid[m] = 1;
        m_data[m]  = int'(d[g*8 +: 8]);
        m_src[m]   = g;
        m_ptr[m]   = (g + 1) % n;
      end else if (o) begin
        m_valid[m] = 0;
      end
    end
    @(posedge clk);
    #1;
    check("valid_n4", 32'(out_valid4), 32'(m_valid[0]));
    check("data_n4",  32'(out_data4),  32'(m_data[0]));
    check("src_n4",   32'(out_src4),   32'(m_src[0]));
    check("valid_n3", 32'(out_valid3), 32'(m_valid[1]));
    check("data_n3",  32'(out_data3),  32'(m_data[1]));
    check("src_n3",   32'(out_src3),   32'(m_src[1]));
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_data[m] = 0; m_src[m] = 0; m_ptr[m] = 0;
    end
    // reset with every request pending: no grants while rst is high
    repeat (2) cycle(1'b1, 4'hF, $urandom, 1'b1);
    // all requesting, sink always ready: full-rate rotation
    repeat (8) cycle(1'b0, 4'hF, $urandom, 1'b1);
    // sparse requesters 1 and 3 only
    cycle(1'b1, 4'h0, 32'h0, 1'b1);
    repeat (6) cycle(1'b0, 4'b1010, $urandom, 1'b1);
    // backpressure: register full and sink stalled
    cycle(1'b0, 4'hF, $urandom, 1'b1);
    repeat (5) cycle(1'b0, 4'hF, $urandom, 1'b0);
    repeat (3) cycle(1'b0, 4'hF, $urandom, 1'b1);
    // reset while holding a word from requester 2
    cycle(1'b1, 4'h0, 32'h0, 1'b1);
    repeat (3) cycle(1'b0, 4'hF, $urandom, 1'b1);
    check("src_before_rst", 32'(out_src4), 32'd2);
    cycle(1'b1, 4'hF, $urandom, 1'b0);
    repeat (3) cycle(1'b0, 4'hF, $urandom, 1'b1);
    // idle cycles leave the pointer alone
    repeat (3) cycle(1'b0, 4'h0, $urandom, 1'b1);
    repeat (2) cycle(1'b0, 4'hF, $urandom, 1'b1);
    // random traffic with occasional reset
    for (int t = 0; t < 400; t++) begin
      cycle(($urandom_range(0, 59) == 0), 4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
